// File: rtl/tl_track_pkg.sv
// Shared opcodes, beat-count helper and the source-indexed size array type
// for the TileLink in-flight tracker.
package tl_track_pkg;

   localparam int TRK_SOURCE_BITS = 3;
   localparam int TRK_SIZE_BITS   = 3;
   localparam int BEATS_W         = 8;

   localparam logic [2:0] A_PUT_FULL        = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
   localparam logic [2:0] D_GRANT_DATA      = 3'd5;

   typedef logic [TRK_SIZE_BITS-1:0] size_arr_t [2**TRK_SOURCE_BITS];

   function automatic logic [BEATS_W-1:0] num_beats(input logic [7:0] size,
                                                    input logic       has_data,
                                                    input int         beat_lg);
      logic [BEATS_W-1:0] n;
      n = BEATS_W'(1);
      if (has_data && (int'(size) > beat_lg))
         n = BEATS_W'(1) << (int'(size) - beat_lg);
      return n;
   endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Beat position counter for one TileLink channel; first/last are
// combinational from the current count and the message length.
module tl_beat_counter
   import tl_track_pkg::*;
#(
   parameter int CNT_BITS = 3
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               fire_i,
   input  logic [BEATS_W-1:0] beats_i,
   output logic               first_o,
   output logic               last_o
);

   logic [CNT_BITS-1:0] count_q, count_d;

   assign first_o = (count_q == '0);
   assign last_o  = (BEATS_W'(count_q) == (beats_i - BEATS_W'(1)));

   always_comb begin
      count_d = count_q;
      if (fire_i) count_d = last_o ? '0 : count_q + CNT_BITS'(1);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) count_q <= '0;
      else         count_q <= count_d;
   end

endmodule

// File: rtl/tl_inflight_tracker.sv
// Per-source outstanding-transaction tracker for one TL-UL/UH link.
// Optional coverage observers under TL_INFLIGHT_TRACKER_COVER_EN.
module tl_inflight_tracker
   import tl_track_pkg::*;
#(
   parameter int SOURCE_BITS = TRK_SOURCE_BITS,
   parameter int SIZE_BITS   = TRK_SIZE_BITS,
   parameter int BEAT_LG     = 3,
   parameter int TIMEOUT     = 4096
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     a_valid_i,
   input  logic                     a_ready_i,
   input  logic [2:0]               a_opcode_i,
   input  logic [SIZE_BITS-1:0]     a_size_i,
   input  logic [SOURCE_BITS-1:0]   a_source_i,
   input  logic                     d_valid_i,
   input  logic                     d_ready_i,
   input  logic [2:0]               d_opcode_i,
   input  logic [SIZE_BITS-1:0]     d_size_i,
   input  logic [SOURCE_BITS-1:0]   d_source_i,
   output logic                     a_first_o,
   output logic                     a_last_o,
   output logic                     d_first_o,
   output logic                     d_last_o,
   output logic [2**SOURCE_BITS-1:0] inflight_o,
   output logic                     err_a_reuse_o,
   output logic                     err_d_orphan_o,
   output logic                     err_d_size_o,
   output logic                     err_timeout_o,
   output logic                     err_any_o
`ifdef TL_INFLIGHT_TRACKER_COVER_EN
   ,
   output logic [SOURCE_BITS:0]     cov_max_inflight_o,
   output logic [31:0]              cov_txn_count_o
`endif
);

   localparam int NSRC = 2**SOURCE_BITS;
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic               a_fire, d_fire, a_has_data, d_has_data;
   logic [BEATS_W-1:0] a_beats, d_beats;
   logic               d_clear_same;
   logic [NSRC-1:0]    inflight_q, inflight_d;
   size_arr_t          size_q;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic               reuse_d, orphan_d, dsize_d, timeout_d, any_d;
   logic               reuse_q, orphan_q, dsize_q, timeout_q, any_q;

   assign a_fire     = a_valid_i & a_ready_i;
   assign d_fire     = d_valid_i & d_ready_i;
   assign a_has_data = (a_opcode_i == A_PUT_FULL) || (a_opcode_i == A_PUT_PARTIAL);
   assign d_has_data = (d_opcode_i == D_ACCESS_ACK_DATA) || (d_opcode_i == D_GRANT_DATA);
   assign a_beats    = num_beats(8'(a_size_i), a_has_data, BEAT_LG);
   assign d_beats    = num_beats(8'(d_size_i), d_has_data, BEAT_LG);

   tl_beat_counter #(.CNT_BITS(SIZE_BITS)) u_a_cnt (
      .clock_i(clock_i), .reset_i(reset_i), .fire_i(a_fire), .beats_i(a_beats),
      .first_o(a_first_o), .last_o(a_last_o));

   tl_beat_counter #(.CNT_BITS(SIZE_BITS)) u_d_cnt (
      .clock_i(clock_i), .reset_i(reset_i), .fire_i(d_fire), .beats_i(d_beats),
      .first_o(d_first_o), .last_o(d_last_o));

   always_comb begin
      inflight_d = inflight_q;
      // Clear before set so a same-source A-last overrides the D-last release.
      if (d_fire && d_last_o) inflight_d[d_source_i] = 1'b0;
      if (a_fire && a_last_o) inflight_d[a_source_i] = 1'b1;

      d_clear_same = d_fire & d_last_o & (d_source_i == a_source_i);
      reuse_d  = a_fire & a_first_o & inflight_q[a_source_i] & ~d_clear_same;
      orphan_d = d_fire & d_first_o & ~inflight_q[d_source_i];
      dsize_d  = d_fire & d_first_o & inflight_q[d_source_i] &
                 (d_size_i != size_q[d_source_i]);

      wd_d = wd_q;
      if (d_fire || (inflight_q == '0)) wd_d = '0;
      else if (wd_q != WD_W'(TIMEOUT))  wd_d = wd_q + WD_W'(1);

      timeout_d = timeout_q | (wd_d == WD_W'(TIMEOUT));
      any_d     = any_q | reuse_d | orphan_d | dsize_d | timeout_d;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         inflight_q <= '0;
         wd_q       <= '0;
         reuse_q    <= 1'b0;
         orphan_q   <= 1'b0;
         dsize_q    <= 1'b0;
         timeout_q  <= 1'b0;
         any_q      <= 1'b0;
         for (int i = 0; i < NSRC; i++) size_q[i] <= '0;
      end else begin
         inflight_q <= inflight_d;
         wd_q       <= wd_d;
         reuse_q    <= reuse_d;
         orphan_q   <= orphan_d;
         dsize_q    <= dsize_d;
         timeout_q  <= timeout_d;
         any_q      <= any_d;
         if (a_fire && a_last_o) size_q[a_source_i] <= a_size_i;
      end
   end

   assign inflight_o     = inflight_q;
   assign err_a_reuse_o  = reuse_q;
   assign err_d_orphan_o = orphan_q;
   assign err_d_size_o   = dsize_q;
   assign err_timeout_o  = timeout_q;
   assign err_any_o      = any_q;

`ifdef TL_INFLIGHT_TRACKER_COVER_EN
   logic [SOURCE_BITS:0] pop_cur, cov_max_q;
   logic [31:0]          txn_q;

   assign pop_cur = (SOURCE_BITS+1)'($countones(inflight_q));

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cov_max_q <= '0;
         txn_q     <= '0;
      end else begin
         if (pop_cur > cov_max_q) cov_max_q <= pop_cur;
         if (d_fire && d_last_o && (txn_q != '1)) txn_q <= txn_q + 32'd1;
      end
   end

   assign cov_max_inflight_o = cov_max_q;
   assign cov_txn_count_o    = txn_q;
`else
   // No coverage observers in this build.
`endif

endmodule
